pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit for the OpenMIPS five-stage core.
- Produces the stall vector and flush pulse consumed by every inter-stage register (pc_reg, if_id, id_ex, ex_mem, mem_wb), and the redirect PC sent to pc_reg on exceptions and eret.
- Arbitrates stall requests from IF (bus fetch), ID, EX and MEM (bus load/store).
- Sequences exception redirects through a small state machine so an in-flight instruction-bus fetch completes before the flush.
- Keeps saturating stall-cycle and flush counters for debug.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect address for every exception except eret.
- CNT_W, 32, width of stall_cycles_o.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stallreq_from_if  in  1  instruction-bus access pending.
- stallreq_from_id  in  1  ID load-use hazard.
- stallreq_from_ex  in  1  EX multi-cycle op (div/madd) busy.
- stallreq_from_mem  in  1  data-bus access pending.
- excepttype_i  in  32  final exception type from MEM stage; 0 means none.
- cp0_epc_i  in  32  current CP0 EPC, bypassed.
- stall  out  6  per-stage stop. Bit mapping: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb. 1 = Stop.
- flush  out  1  clear all pipeline registers.
- new_pc  out  32  redirect target; valid while flush = 1.
- stall_cycles_o  out  CNT_W  cycles in RUN with stall[0] = 1; saturates at all-ones.
- flush_count_o  out  16  number of flushes issued; saturates at 16'hFFFF.

Behaviour:
- Reset (rst = 1 at a clock edge): state = RUN, flush = 0, new_pc = 0, both counters = 0, latched type/EPC = 0. stall is combinational from state, so it reads 6'b000000 in RUN with no requests.
- Reset has priority over everything, including mid-HOLD or mid-FLUSH. Any pending exception is discarded.
- States: RUN, HOLD, FLUSH. state and the latched type/EPC are registers. flush = (state == FLUSH).
- RUN, excepttype_i == 0: stall is combinational, highest priority first:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000111
  - none → 6'b000000
- RUN, excepttype_i != 0:
  - stall = 6'b111111 this cycle, freezing all stages.
  - Latch excepttype_i and cp0_epc_i.
  - Next state = HOLD if stallreq_from_if = 1, else FLUSH.
  - The exception overrides all stall requests.
- HOLD:
  - stall = 6'b111111.
  - excepttype_i and cp0_epc_i are ignored; the latched values stand.
  - Next state = FLUSH on the first cycle with stallreq_from_if = 0.
  - No timeout.
- FLUSH (exactly one cycle):
  - flush = 1, stall = 6'b000000.
  - new_pc = latched EPC if the latched type == 32'h0000000e (eret), else EXC_VECTOR.
  - Next state = RUN unconditionally.
  - excepttype_i in this cycle is ignored, because the flush clears its source.
- new_pc is 0 outside FLUSH.
- Latency: exception seen in cycle N with the IF bus idle → flush = 1 in cycle N+1. Each extra cycle of stallreq_from_if adds one cycle.
- stall_cycles_o increments in RUN when stall[0] = 1. It does not count HOLD or the exception-detect cycle.
- flush_count_o increments on entry to FLUSH.
- Both counters hold at all-ones once saturated.
- Back-to-back exceptions: the earliest RUN cycle at which a second exception can be accepted is N+2.

Test Plan:
- Reset: assert rst 2 cycles with all requests = 1 and excepttype_i = 32'h8 → after release: stall = 0 until inputs are sampled in RUN, flush = 0, new_pc = 0, counters = 0.
- Stall priority: drive id = 1 → stall = 6'h07. Add ex → 6'h0F. Add mem → 6'h1F. Only if = 1 → 6'h07. After 4 such cycles, stall_cycles_o = 4.
- Syscall, IF idle: excepttype_i = 32'h8 for one cycle → that cycle stall = 6'h3F; next cycle flush = 1, new_pc = 32'h20, stall = 0; following cycle flush = 0; flush_count_o = 1.
- Eret during IF bus wait: excepttype_i = 32'he, cp0_epc_i = 32'hBFC00100, stallreq_from_if = 1 for 3 more cycles; change cp0_epc_i during the wait → stall = 6'h3F for 4 cycles, then flush = 1 with new_pc = 32'hBFC00100 (the latched value).
- Reset mid-HOLD: enter HOLD, assert rst → flush never pulses, state = RUN, flush_count_o = 0.
- Exception during FLUSH: excepttype_i = 32'hc held 2 cycles → exactly one flush pulse; a third cycle with the exception still high starts a new detect (stall = 6'h3F).

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control for the OpenMIPS five-stage core: stall arbitration, exception
// redirect sequencing (RUN -> HOLD -> FLUSH) and saturating debug counters.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h00000020,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_if,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             stallreq_from_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [15:0]      flush_count_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [31:0]      EXC_ERET   = 32'h0000000e;
    localparam logic [5:0]       STALL_ALL  = 6'b111111;
    localparam logic [5:0]       STALL_MEM  = 6'b011111;
    localparam logic [5:0]       STALL_EX   = 6'b001111;
    localparam logic [5:0]       STALL_ID   = 6'b000111;
    localparam logic [CNT_W-1:0] STALL_ONE  = CNT_W'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_type;
    logic [31:0]       r_epc;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [15:0]       r_flush_count;

    logic              w_exc;
    logic [5:0]        w_run_stall;
    logic              w_count_stall;
    logic              w_enter_flush;

    assign w_exc = |excepttype_i;

    // Normal-operation stall vector; IF and ID hazards both freeze pc/if/id.
    always_comb begin
        if (stallreq_from_mem)
            w_run_stall = STALL_MEM;
        else if (stallreq_from_ex)
            w_run_stall = STALL_EX;
        else if (stallreq_from_id || stallreq_from_if)
            w_run_stall = STALL_ID;
        else
            w_run_stall = 6'b000000;
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_RUN;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_exc)
                    w_next_state = stallreq_from_if ? ST_HOLD : ST_FLUSH;
            end
            ST_HOLD: begin
                if (!stallreq_from_if)
                    w_next_state = ST_FLUSH;
            end
            ST_FLUSH: w_next_state = ST_RUN;
            default:  w_next_state = ST_RUN;
        endcase
    end

    always_comb begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = 32'h0;
        case (r_state)
            ST_RUN:  stall = w_exc ? STALL_ALL : w_run_stall;
            ST_HOLD: stall = STALL_ALL;
            ST_FLUSH: begin
                flush  = 1'b1;
                new_pc = (r_type == EXC_ERET) ? r_epc : EXC_VECTOR;
            end
            default: stall = 6'b000000;
        endcase
    end

    // Exception type and EPC are captured only on the detect cycle; HOLD ignores the live inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_type <= 32'h0;
            r_epc  <= 32'h0;
        end else if (r_state == ST_RUN && w_exc) begin
            r_type <= excepttype_i;
            r_epc  <= cp0_epc_i;
        end
    end

    // Only genuine RUN stalls count; the exception-detect cycle and HOLD do not.
    assign w_count_stall = (r_state == ST_RUN) && !w_exc && w_run_stall[0];
    assign w_enter_flush = (w_next_state == ST_FLUSH) && (r_state != ST_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= 16'h0;
        end else begin
            if (w_count_stall && !(&r_stall_cycles))
                r_stall_cycles <= r_stall_cycles + STALL_ONE;
            if (w_enter_flush && !(&r_flush_count))
                r_flush_count <= r_flush_count + 16'h1;
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign flush_count_o  = r_flush_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vectors with literal expectations plus
// an every-cycle comparison against a behavioural model of the control rules.
module tb_pipe_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_if, req_id, req_ex, req_mem;
    logic [31:0]      exc_type;
    logic [31:0]      epc;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic [CNT_W-1:0] stall_cycles;
    logic [15:0]      flush_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    pipe_ctrl #(.EXC_VECTOR(32'h00000020), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (req_if),
        .stallreq_from_id  (req_id),
        .stallreq_from_ex  (req_ex),
        .stallreq_from_mem (req_mem),
        .excepttype_i      (exc_type),
        .cp0_epc_i         (epc),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .stall_cycles_o    (stall_cycles),
        .flush_count_o     (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: "waiting" = exception accepted but IF bus still busy,
    // "flushing" = this cycle is the redirect cycle.
    bit          m_waiting;
    bit          m_flushing;
    logic [31:0] m_type;
    logic [31:0] m_epc;
    int          m_stalls;
    int          m_flushes;

    function automatic logic [5:0] model_stall();
        int depth;
        if (m_flushing) return 6'd0;
        if (m_waiting || exc_type != 0) return 6'h3F;
        // number of frozen stages counted from the pc end
        depth = req_mem ? 5 : req_ex ? 4 : (req_id || req_if) ? 3 : 0;
        return 6'((1 << depth) - 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_waiting  <= 1'b0;
            m_flushing <= 1'b0;
            m_type     <= 32'h0;
            m_epc      <= 32'h0;
            m_stalls   <= 0;
            m_flushes  <= 0;
        end else if (m_flushing) begin
            m_flushing <= 1'b0;
        end else if (m_waiting) begin
            if (!req_if) begin
                m_waiting  <= 1'b0;
                m_flushing <= 1'b1;
                m_flushes  <= m_flushes + 1;
            end
        end else if (exc_type != 0) begin
            m_type <= exc_type;
            m_epc  <= epc;
            if (req_if) begin
                m_waiting <= 1'b1;
            end else begin
                m_flushing <= 1'b1;
                m_flushes  <= m_flushes + 1;
            end
        end else if (req_if || req_id || req_ex || req_mem) begin
            m_stalls <= (m_stalls < CNT_SAT) ? m_stalls + 1 : CNT_SAT;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_stall", 64'(stall), 64'(model_stall()));
            check("model_flush", 64'(flush), 64'(m_flushing));
            check("model_new_pc", 64'(new_pc),
                  m_flushing ? 64'((m_type == 32'he) ? m_epc : 32'h20) : 64'd0);
            check("model_stall_cycles", 64'(stall_cycles), 64'(m_stalls));
            check("model_flush_count", 64'(flush_count), 64'(m_flushes));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_if = 0; req_id = 0; req_ex = 0; req_mem = 0;
        exc_type = 32'h0;
    endtask

    initial begin
        // Reset with every request and an exception active
        rst = 1; req_if = 1; req_id = 1; req_ex = 1; req_mem = 1;
        exc_type = 32'h8; epc = 32'h12345678;
        step();
        chk_en = 1'b1;
        step();
        rst = 0;
        idle_inputs();
        epc = 32'h0;
        @(negedge clk);
        check("rst_stall", 64'(stall), 64'h0);
        check("rst_flush", 64'(flush), 64'h0);
        check("rst_new_pc", 64'(new_pc), 64'h0);
        check("rst_stall_cycles", 64'(stall_cycles), 64'h0);
        check("rst_flush_count", 64'(flush_count), 64'h0);

        // Stall priority
        step(); req_id = 1;
        @(negedge clk); check("prio_id", 64'(stall), 64'h07);
        step(); req_ex = 1;
        @(negedge clk); check("prio_ex", 64'(stall), 64'h0F);
        step(); req_mem = 1;
        @(negedge clk); check("prio_mem", 64'(stall), 64'h1F);
        step(); req_id = 0; req_ex = 0; req_mem = 0; req_if = 1;
        @(negedge clk); check("prio_if", 64'(stall), 64'h07);
        step(); idle_inputs();
        @(negedge clk); check("prio_count", 64'(stall_cycles), 64'd4);

        // Syscall with IF idle
        step(); exc_type = 32'h8;
        @(negedge clk); check("sys_detect_stall", 64'(stall), 64'h3F);
        step(); exc_type = 32'h0;
        @(negedge clk);
        check("sys_flush", 64'(flush), 64'h1);
        check("sys_new_pc", 64'(new_pc), 64'h20);
        check("sys_flush_stall", 64'(stall), 64'h0);
        step();
        @(negedge clk);
        check("sys_flush_drop", 64'(flush), 64'h0);
        check("sys_flush_count", 64'(flush_count), 64'd1);

        // Eret while the IF bus is busy; EPC input changes during the wait
        step(); exc_type = 32'he; epc = 32'hBFC00100; req_if = 1;
        @(negedge clk); check("eret_stall_0", 64'(stall), 64'h3F);
        step(); exc_type = 32'h0; epc = 32'hDEADBEEF;
        @(negedge clk); check("eret_stall_1", 64'(stall), 64'h3F);
        step();
        @(negedge clk); check("eret_stall_2", 64'(stall), 64'h3F);
        step(); req_if = 0;
        @(negedge clk);
        check("eret_stall_3", 64'(stall), 64'h3F);
        check("eret_no_flush_yet", 64'(flush), 64'h0);
        step();
        @(negedge clk);
        check("eret_flush", 64'(flush), 64'h1);
        check("eret_new_pc", 64'(new_pc), 64'hBFC00100);
        step(); epc = 32'h0;
        @(negedge clk); check("eret_flush_count", 64'(flush_count), 64'd2);

        // Reset while in HOLD
        step(); exc_type = 32'h8; req_if = 1;
        step(); exc_type = 32'h0;
        @(negedge clk); check("hold_stall", 64'(stall), 64'h3F);
        step(); rst = 1; req_if = 0;
        step(); rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_rst_flush", 64'(flush), 64'h0);
            check("hold_rst_stall", 64'(stall), 64'h0);
            step();
        end
        check("hold_rst_flush_count", 64'(flush_count), 64'd0);

        // Exception held through the flush cycle
        exc_type = 32'hc;
        @(negedge clk); check("hold_exc_detect", 64'(stall), 64'h3F);
        step();
        @(negedge clk);
        check("hold_exc_flush", 64'(flush), 64'h1);
        check("hold_exc_pc", 64'(new_pc), 64'h20);
        step();
        @(negedge clk);
        check("hold_exc_redetect", 64'(stall), 64'h3F);
        check("hold_exc_no_flush", 64'(flush), 64'h0);
        step(); exc_type = 32'h0;
        @(negedge clk);
        check("hold_exc_second_flush", 64'(flush), 64'h1);
        check("hold_exc_count", 64'(flush_count), 64'd2);

        // Stall counter saturation
        step(); req_mem = 1;
        for (int i = 0; i < CNT_SAT + 5; i++) step();
        req_mem = 0;
        @(negedge clk); check("stall_saturate", 64'(stall_cycles), 64'(CNT_SAT));
        step();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
